rom_sdram_loader: RTL and testbench

Parametrised successor to the top-level ROM-to-SDRAM copy state machine. It streams `byte_count` bytes from a combinational byte-wide ROM and packs them little-endian into DATA_WIDTH words. It writes the words through an Avalon-style SDRAM controller port, honouring waitrequest, and can optionally read every word back and compare it. It sits between the program ROM and the SDRAM controller, and signals the CPU fetch logic via `done`/`error`.

---
 rtl/rom_sdram_loader_pkg.sv | 25 ++
 rtl/rom_sdram_loader_if.sv | 31 +++
 rtl/rom_sdram_loader_byte_packer.sv | 68 ++++++
 rtl/rom_sdram_loader.sv | 189 ++++++++++++++++++
 tb/tb_rom_sdram_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_sdram_loader_pkg.sv
// Shared definitions for the ROM-to-SDRAM loader: controller state encoding
// and the helpers that derive the byte-lane geometry from the data width.
package rom_sdram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STABILIZE,
    GATHER,
    WRITE,
    VERIFY_RD,
    VERIFY_WAIT,
    DONE
  } loaderState_e;

  // Number of byte lanes in one SDRAM word
  function automatic int bytesOf(input int dataWidth);
    return dataWidth / 8;
  endfunction

  // Width of a lane index; a single-lane word still gets a 1-bit index
  function automatic int laneWidthOf(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/rom_sdram_loader_if.sv
// Avalon-style SDRAM controller port used by the loader. The loader is the
// master; the SDRAM controller (or a bench model of it) is the slave.
interface rom_sdram_loader_if
  import rom_sdram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16
);
  localparam int BYTES = bytesOf(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] address;
  logic [BYTES-1:0]      be_n;
  logic                  cs;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  rd_n;
  logic                  wr_n;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, be_n, cs, writedata, rd_n, wr_n,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, be_n, cs, writedata, rd_n, wr_n,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/rom_sdram_loader_byte_packer.sv
// Assembles ROM bytes into one little-endian SDRAM word. A byte landing in
// lane 0 starts a fresh word: every other lane is zeroed and disabled, so a
// short final word leaves its unused lanes at data 0 / be_n 1. The same
// register holds the expected word during read-back, and the compare only
// looks at lanes that were actually filled.
module loader_byte_packer
  import rom_sdram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BYTES      = bytesOf(DATA_WIDTH),
  parameter int LW         = laneWidthOf(BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [LW-1:0]         lane_i,
  input  logic [7:0]            byte_i,
  input  logic [DATA_WIDTH-1:0] cmp_data_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic [BYTES-1:0]      be_n_o,
  output logic                  match_o
);

  logic [DATA_WIDTH-1:0] wordData_q, wordData_d;
  logic [BYTES-1:0]      beN_q, beN_d;

  // Place the incoming byte in its lane, clearing the rest on a new word
  always_comb begin
    wordData_d = wordData_q;
    beN_d      = beN_q;
    if (load_i) begin
      for (int l = 0; l < BYTES; l++) begin
        if (LW'(l) == lane_i) begin
          wordData_d[l*8 +: 8] = byte_i;
          beN_d[l]             = 1'b0;
        end else if (lane_i == '0) begin
          wordData_d[l*8 +: 8] = 8'h00;
          beN_d[l]             = 1'b1;
        end
      end
    end
  end

  // Word and lane-enable registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordData_q <= '0;
      beN_q      <= '0;
    end else begin
      wordData_q <= wordData_d;
      beN_q      <= beN_d;
    end
  end

  // Read-back compare over enabled lanes only
  always_comb begin
    match_o = 1'b1;
    for (int l = 0; l < BYTES; l++) begin
      if (!beN_q[l] && (cmp_data_i[l*8 +: 8] != wordData_q[l*8 +: 8])) begin
        match_o = 1'b0;
      end
    end
  end

  assign word_o = wordData_q;
  assign be_n_o = beN_q;

endmodule

// File: rtl/rom_sdram_loader.sv
// Copies byte_count bytes from the program ROM into SDRAM after the
// controller has finished initialising, optionally reading every word back
// to confirm it. CPU fetch logic waits on done and inspects error.
module rom_sdram_loader
  import rom_sdram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 16,
  parameter int SRC_ADDR_WIDTH = 32,
  parameter int VERIFY         = 1,
  parameter int INIT_WAIT      = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      init_done_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [SRC_ADDR_WIDTH-1:0] byte_count_i,
  output logic [SRC_ADDR_WIDTH-1:0] src_address_o,
  input  logic [7:0]                src_byte_i,
  rom_sdram_loader_if.master        avm,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [ADDR_WIDTH-1:0]     error_addr_o
);

  localparam int BYTES = bytesOf(DATA_WIDTH);
  localparam int LW    = laneWidthOf(BYTES);

  loaderState_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]     baseAddr_q, baseAddr_d;
  logic [SRC_ADDR_WIDTH-1:0] byteCount_q, byteCount_d;
  logic [SRC_ADDR_WIDTH-1:0] srcAddr_q, srcAddr_d;
  logic [ADDR_WIDTH-1:0]     wordIdx_q, wordIdx_d;
  logic [31:0]               stabCnt_q, stabCnt_d;
  logic                      reqPhase_q, reqPhase_d;
  logic                      error_q, error_d;
  logic [ADDR_WIDTH-1:0]     errorAddr_q, errorAddr_d;

  logic [LW-1:0]         lane;
  logic                  lastByte;
  logic                  moreBytes;
  logic                  capture;
  logic                  wordMatch;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [DATA_WIDTH-1:0] packWord;
  logic [BYTES-1:0]      packBeN;

  assign lane      = LW'(srcAddr_q % SRC_ADDR_WIDTH'(BYTES));
  assign lastByte  = (srcAddr_q == byteCount_q - SRC_ADDR_WIDTH'(1)) ||
                     (lane == LW'(BYTES - 1));
  assign moreBytes = (srcAddr_q < byteCount_q);
  assign wordAddr  = baseAddr_q + wordIdx_q;
  assign capture   = (state_q == GATHER) || ((state_q == VERIFY_RD) && !reqPhase_q);

  loader_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (capture),
    .lane_i     (lane),
    .byte_i     (src_byte_i),
    .cmp_data_i (avm.readdata),
    .word_o     (packWord),
    .be_n_o     (packBeN),
    .match_o    (wordMatch)
  );

  // Next-state logic for the copy / verify sequence
  always_comb begin
    state_d     = state_q;
    baseAddr_d  = baseAddr_q;
    byteCount_d = byteCount_q;
    srcAddr_d   = srcAddr_q;
    wordIdx_d   = wordIdx_q;
    stabCnt_d   = stabCnt_q;
    reqPhase_d  = reqPhase_q;
    error_d     = error_q;
    errorAddr_d = errorAddr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          baseAddr_d  = base_addr_i;
          byteCount_d = byte_count_i;
          srcAddr_d   = '0;
          wordIdx_d   = '0;
          stabCnt_d   = '0;
          reqPhase_d  = 1'b0;
          error_d     = 1'b0;
          errorAddr_d = '0;
          state_d     = (byte_count_i == '0) ? DONE : STABILIZE;
        end
      end
      STABILIZE: begin
        if (!init_done_i) begin
          stabCnt_d = '0;
        end else if (stabCnt_q + 32'd1 >= 32'(INIT_WAIT)) begin
          stabCnt_d = '0;
          state_d   = GATHER;
        end else begin
          stabCnt_d = stabCnt_q + 32'd1;
        end
      end
      GATHER: begin
        srcAddr_d = srcAddr_q + SRC_ADDR_WIDTH'(1);
        if (lastByte) state_d = WRITE;
      end
      WRITE: begin
        if (!avm.waitrequest) begin
          wordIdx_d = wordIdx_q + ADDR_WIDTH'(1);
          if (moreBytes) begin
            state_d = GATHER;
          end else if (VERIFY != 0) begin
            wordIdx_d  = '0;
            srcAddr_d  = '0;
            reqPhase_d = 1'b0;
            state_d    = VERIFY_RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      VERIFY_RD: begin
        if (!reqPhase_q) begin
          srcAddr_d = srcAddr_q + SRC_ADDR_WIDTH'(1);
          if (lastByte) reqPhase_d = 1'b1;
        end else if (!avm.waitrequest) begin
          reqPhase_d = 1'b0;
          state_d    = VERIFY_WAIT;
        end
      end
      VERIFY_WAIT: begin
        if (avm.readdatavalid) begin
          if (!wordMatch) begin
            error_d     = 1'b1;
            errorAddr_d = wordAddr;
            state_d     = DONE;
          end else begin
            wordIdx_d = wordIdx_q + ADDR_WIDTH'(1);
            state_d   = moreBytes ? VERIFY_RD : DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      baseAddr_q  <= '0;
      byteCount_q <= '0;
      srcAddr_q   <= '0;
      wordIdx_q   <= '0;
      stabCnt_q   <= '0;
      reqPhase_q  <= 1'b0;
      error_q     <= 1'b0;
      errorAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      baseAddr_q  <= baseAddr_d;
      byteCount_q <= byteCount_d;
      srcAddr_q   <= srcAddr_d;
      wordIdx_q   <= wordIdx_d;
      stabCnt_q   <= stabCnt_d;
      reqPhase_q  <= reqPhase_d;
      error_q     <= error_d;
      errorAddr_q <= errorAddr_d;
    end
  end

  assign avm.address   = wordAddr;
  assign avm.be_n      = packBeN;
  assign avm.cs        = 1'b1;
  assign avm.writedata = packWord;
  assign avm.wr_n      = (state_q != WRITE);
  assign avm.rd_n      = !((state_q == VERIFY_RD) && reqPhase_q);

  assign src_address_o = srcAddr_q;
  assign busy_o        = (state_q != IDLE) && (state_q != DONE);
  assign done_o        = (state_q == DONE);
  assign error_o       = error_q;
  assign error_addr_o  = errorAddr_q;

endmodule

// File: tb/tb_rom_sdram_loader.sv
// Bench for the ROM-to-SDRAM loader: a combinational ROM, a reactive SDRAM
// controller model with optional stalls, read latency and read-back
// corruption, and a word-level reference of what the copy must produce.
module tb_rom_sdram_loader;
  localparam int AW    = 22;
  localparam int DW    = 16;
  localparam int SW    = 32;
  localparam int IW    = 20;
  localparam int B     = DW / 8;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic          init_done_i;
  logic [AW-1:0] base_addr_i;
  logic [SW-1:0] byte_count_i;
  logic [SW-1:0] srcAddress;
  logic [7:0]    srcByte;
  logic          busy, done, error;
  logic [AW-1:0] errorAddr;

  logic [7:0] rom [256];
  int errors = 0;
  int checks = 0;

  rom_sdram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avm ();

  rom_sdram_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_ADDR_WIDTH(SW), .VERIFY(1), .INIT_WAIT(IW)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .init_done_i(init_done_i),
    .base_addr_i(base_addr_i), .byte_count_i(byte_count_i),
    .src_address_o(srcAddress), .src_byte_i(srcByte), .avm(avm),
    .busy_o(busy), .done_o(done), .error_o(error), .error_addr_o(errorAddr)
  );

  always #5 clk = ~clk;
  assign srcByte = rom[srcAddress[7:0]];

  // Controller model state
  int cyc = 0, startCyc = 0, riseCyc = 0, rdAccepts = 0, rdCnt = 0, wrLowCnt = 0;
  int corruptIdx = -1, curBase = 0;
  bit randStallEn = 0, spurEn = 0, stallWatch = 0;
  logic initPrev = 1'b0;
  logic randStall_q;
  logic [AW-1:0] rdAddr;
  logic [15:0] mem [int];
  int wrAddrQ[$], wrDataQ[$], wrBeQ[$], wrCycQ[$], stallAddrQ[$], stallDataQ[$];

  assign avm.waitrequest = randStall_q | (stallWatch && wrLowCnt < 5);

  // Reactive SDRAM controller: logs writes, returns reads after a latency
  always @(posedge clk) begin
    logic [15:0] word;
    cyc <= cyc + 1;
    initPrev <= init_done_i;
    if (init_done_i && !initPrev) riseCyc <= cyc;
    if (start_i && !busy && !done) startCyc <= cyc;
    if (reset) begin
      avm.readdatavalid <= 1'b0;
      avm.readdata      <= '0;
      randStall_q       <= 1'b0;
      rdCnt             <= 0;
    end else begin
      randStall_q       <= randStallEn && ($urandom_range(0, 2) == 0);
      avm.readdatavalid <= 1'b0;
      if (spurEn && !avm.wr_n && $urandom_range(0, 3) == 0) begin
        avm.readdatavalid <= 1'b1;
        avm.readdata      <= 16'($urandom);
      end
      if (rdCnt > 0) begin
        rdCnt <= rdCnt - 1;
        if (rdCnt == 1) begin
          word = mem.exists(int'(rdAddr)) ? mem[int'(rdAddr)] : 16'($urandom);
          if (((int'(rdAddr) - curBase) & AMASK) == corruptIdx) word = word ^ 16'h0001;
          avm.readdatavalid <= 1'b1;
          avm.readdata      <= word;
        end
      end
      if (!avm.rd_n && !avm.waitrequest) begin
        rdAccepts <= rdAccepts + 1;
        rdAddr    <= avm.address;
        rdCnt     <= $urandom_range(1, 3);
      end
      if (!stallWatch) wrLowCnt <= 0;
      else if (!avm.wr_n && wrAddrQ.size() == 0) begin
        wrLowCnt <= wrLowCnt + 1;
        stallAddrQ.push_back(int'(avm.address));
        stallDataQ.push_back(int'(avm.writedata));
      end
      if (!avm.wr_n && !avm.waitrequest) begin
        word = mem.exists(int'(avm.address)) ? mem[int'(avm.address)] : 16'($urandom);
        for (int l = 0; l < B; l++)
          if (!avm.be_n[l]) word[l*8 +: 8] = avm.writedata[l*8 +: 8];
        mem[int'(avm.address)] = word;
        wrAddrQ.push_back(int'(avm.address));
        wrDataQ.push_back(int'(avm.writedata));
        wrBeQ.push_back(int'(avm.be_n));
        wrCycQ.push_back(cyc);
      end
    end
  end

  // Reference: little-endian packing of ROM bytes, unused lanes zero
  function automatic int expWord(input int w, input int count);
    int v = 0;
    for (int l = 0; l < B; l++)
      if (w * B + l < count) v = v | (int'(rom[(w * B + l) % 256]) << (8 * l));
    return v;
  endfunction

  function automatic int expBe(input int w, input int count);
    int v = 0;
    for (int l = 0; l < B; l++)
      if (w * B + l >= count) v = v | (1 << l);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One complete copy: start, wait for done, compare against the reference
  task automatic applyStimulus(input int base, input int count, input int corrupt, input bit stall,
                               input bit dblStart, input bit initGlitch, input bit checkTiming);
    int  words, cycles, expReads, rd0;
    bit  expErr;
    words = (count + B - 1) / B;
    wrAddrQ.delete(); wrDataQ.delete(); wrBeQ.delete(); wrCycQ.delete();
    stallAddrQ.delete(); stallDataQ.delete();
    corruptIdx = corrupt; curBase = base; randStallEn = stall; spurEn = 1;
    rd0 = rdAccepts;
    init_done_i  = !initGlitch;
    base_addr_i  = AW'(base);
    byte_count_i = SW'(count);
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("busyAfterStart", busy, (count > 0));
    cycles = 0;
    while (!done && cycles < 4000) begin
      if (initGlitch) init_done_i = (cycles >= 4 && cycles < 14) || cycles >= 17;
      if (dblStart && cycles == 3) begin
        start_i     = 1'b1;
        base_addr_i = base_addr_i ^ 22'h155;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      cycles++;
    end
    checkOutput("doneSeen", done, 1);
    init_done_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("donePulse", done, 0);
    checkOutput("busyAfterDone", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("wrCount", wrAddrQ.size(), words);
    for (int w = 0; w < words && w < wrAddrQ.size(); w++) begin
      checkOutput("wrAddr", wrAddrQ[w], (base + w) & AMASK);
      checkOutput("wrData", wrDataQ[w], expWord(w, count));
      checkOutput("wrBeN", wrBeQ[w], expBe(w, count));
    end
    expErr   = (corrupt >= 0) && (corrupt < words);
    expReads = expErr ? corrupt + 1 : words;
    checkOutput("rdCount", rdAccepts - rd0, expReads);
    checkOutput("errorFlag", error, expErr);
    if (expErr) checkOutput("errorAddr", errorAddr, (base + corrupt) & AMASK);
    if (checkTiming && words > 0 && wrCycQ.size() == words)
      checkOutput("writeLatency", wrCycQ[$] - startCyc, IW + count + words);
    if (initGlitch && wrCycQ.size() > 0)
      checkOutput("initRestart", wrCycQ[0] - riseCyc, IW + B);
    randStallEn = 0;
  endtask

  initial begin
    int base, count, words, corrupt, n;
    reset = 1'b1; start_i = 1'b0; init_done_i = 1'b1;
    base_addr_i = '0; byte_count_i = '0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAddr", avm.address, 0);
    checkOutput("rstBeN", avm.be_n, 0);
    checkOutput("rstCs", avm.cs, 1);
    checkOutput("rstWdata", avm.writedata, 0);
    checkOutput("rstRdN", avm.rd_n, 1);
    checkOutput("rstWrN", avm.wr_n, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstError", error, 0);
    checkOutput("rstErrAddr", errorAddr, 0);
    checkOutput("rstSrcAddr", srcAddress, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(32'h100, 4, -1, 0, 0, 0, 1);
    applyStimulus(32'h200, 3, -1, 0, 0, 0, 1);

    stallWatch = 1;
    applyStimulus(32'h300, 4, -1, 0, 0, 0, 0);
    checkOutput("stallLen", stallAddrQ.size(), 6);
    for (int i = 0; i < stallAddrQ.size(); i++) begin
      checkOutput("stallAddr", stallAddrQ[i], 32'h300);
      checkOutput("stallData", stallDataQ[i], expWord(0, 4));
    end
    stallWatch = 0;

    applyStimulus(32'h400, 4, 1, 0, 0, 0, 0);
    applyStimulus(32'h500, 6, -1, 0, 0, 1, 0);

    base_addr_i = 22'h600; byte_count_i = 32'd8; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (avm.wr_n && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reachWrite", avm.wr_n, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMidWrN", avm.wr_n, 1);
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidSrc", srcAddress, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(32'h700, 6, -1, 0, 0, 0, 1);

    applyStimulus(32'h800, 0, -1, 0, 0, 0, 0);

    for (int it = 0; it < 12; it++) begin
      base    = ($urandom_range(0, 3) == 0) ? AMASK - int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, AMASK));
      count   = $urandom_range(1, 40);
      words   = (count + B - 1) / B;
      corrupt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, words)) : -1;
      n       = $urandom_range(0, 1);
      applyStimulus(base, count, corrupt, bit'(n), bit'($urandom_range(0, 1)), 0, (n == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
